march_ctrl: RTL and testbench

MARCH_CTRL -- requirements
Module: march_ctrl

---
 rtl/march_ctrl_if.sv | 26 ++
 rtl/march_ctrl.sv | 160 ++++++++++++++++
 tb/tb_march_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/march_ctrl_if.sv
// rtl/march_ctrl_if.sv - configuration handshake bundle for march_ctrl
interface march_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_mode;
  logic [7:0]       cfg_passes;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_mode,
    output cfg_passes,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_mode,
    input  cfg_passes,
    output cfg_ready
  );
endinterface

// File: rtl/march_ctrl.sv
// rtl/march_ctrl.sv - one-hot marching-light sequencer with bounce/rotate/hold modes
module march_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  march_ctrl_if.slave cfg,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  o,
  output logic        dir,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTL   = 2'd1;
  localparam logic [1:0] MODE_ROTR   = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       passes_q, passes_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [7:0]       o_q, o_d;
  logic             dir_q, dir_d;

  logic       cfg_fire;
  logic       run_req;
  logic       tick;
  logic       end_hit;
  logic       complete;
  logic [1:0] load_mode;
  logic [7:0] step_o;
  logic       step_dir;

  // A config accepted on the start edge must already steer the start load.
  always_comb begin
    cfg_fire  = (state_q == IDLE) && cfg.cfg_valid;
    load_mode = cfg_fire ? cfg.cfg_mode : mode_q;
    run_req   = (state_q == IDLE) && start && !stop;
    tick      = (cnt_q == div_q);
  end

  // Rotates keep o one-hot even if a shift would otherwise fall off an end.
  always_comb begin
    step_o   = o_q;
    step_dir = dir_q;
    case (mode_q)
      MODE_BOUNCE: begin
        if (dir_q) begin
          step_o = {o_q[0], o_q[7:1]};
          if (step_o == 8'h01) step_dir = 1'b0;
        end else begin
          step_o = {o_q[6:0], o_q[7]};
          if (step_o == 8'h80) step_dir = 1'b1;
        end
      end
      MODE_ROTL: step_o = {o_q[6:0], o_q[7]};
      MODE_ROTR: step_o = {o_q[0], o_q[7:1]};
      default:   step_o = o_q;
    endcase
    end_hit  = (mode_q != MODE_HOLD) && ((step_o == 8'h80) || (step_o == 8'h01));
    complete = tick && end_hit && (passes_q != 8'd0) && ((pass_cnt_q + 8'd1) == passes_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_req) state_d = RUN;
      RUN: begin
        if (stop)          state_d = IDLE;
        else if (complete) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg.cfg_ready = (state_q == IDLE);
    busy          = (state_q == RUN);
    done          = (state_q == DONE);
  end

  always_comb begin
    div_d      = div_q;
    mode_d     = mode_q;
    passes_d   = passes_q;
    cnt_d      = cnt_q;
    pass_cnt_d = pass_cnt_q;
    o_d        = o_q;
    dir_d      = dir_q;
    if (cfg_fire) begin
      div_d    = cfg.cfg_div;
      mode_d   = cfg.cfg_mode;
      passes_d = cfg.cfg_passes;
    end
    if (run_req) begin
      cnt_d      = '0;
      pass_cnt_d = '0;
      if (load_mode == MODE_ROTR) begin
        o_d   = 8'h80;
        dir_d = 1'b1;
      end else begin
        o_d   = 8'h01;
        dir_d = 1'b0;
      end
    end else if ((state_q == RUN) && !stop) begin
      if (tick) begin
        cnt_d = '0;
        o_d   = step_o;
        dir_d = step_dir;
        if (end_hit) pass_cnt_d = pass_cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      mode_q     <= '0;
      passes_q   <= '0;
      cnt_q      <= '0;
      pass_cnt_q <= '0;
      o_q        <= 8'h01;
      dir_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      mode_q     <= mode_d;
      passes_q   <= passes_d;
      cnt_q      <= cnt_d;
      pass_cnt_q <= pass_cnt_d;
      o_q        <= o_d;
      dir_q      <= dir_d;
    end
  end

  assign o   = o_q;
  assign dir = dir_q;

endmodule

// File: tb/tb_march_ctrl.sv
// tb/tb_march_ctrl.sv - table and scoreboard bench for march_ctrl
module tb_march_ctrl;
  localparam int DIV_W = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [7:0] o;
  logic       dir, busy, done;

  march_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

  march_ctrl #(.DIV_W(DIV_W)) dut (
    .clock (clock),
    .reset (reset),
    .cfg   (cfg_if),
    .start (start),
    .stop  (stop),
    .o     (o),
    .dir   (dir),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [7:0] o;
    logic       dir;
  } exp_t;

  typedef struct {
    int div;
    int mode;
    int passes;
    bit same;
    int first_o;
    int first_dir;
    int run_cyc;
    int last_o;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[7];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("onehot", int'($onehot(o)), 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", int'(busy), 0);
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("sb_o", int'(o), int'(e.o));
        chk("sb_dir", int'(dir), int'(e.dir));
      end
    end
  end

  // Position model: bit index walks 0..7 and back, or wraps, independent of mode encoding in the DUT.
  task automatic push_run(input int k0, input int div, input int mode, input int passes, input int max_steps);
    int pos, d, hits;
    logic dv;
    pos  = (mode == 2) ? 7 : 0;
    dv   = (mode == 2);
    d    = 1;
    hits = 0;
    sb.push_back('{k0, 8'(1 << pos), dv});
    for (int i = 1; i <= max_steps; i++) begin
      case (mode)
        0: begin
          pos += d;
          if (pos == 7) d = -1;
          if (pos == 0) d = 1;
          dv = (d < 0);
        end
        1: pos = (pos + 1) % 8;
        2: pos = (pos + 7) % 8;
        default: ;
      endcase
      sb.push_back('{k0 + i * (div + 1), 8'(1 << pos), dv});
      if (mode != 3 && (pos == 0 || pos == 7)) hits++;
      if (passes != 0 && hits == passes) break;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input int div, input int mode, input int passes);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_div    = DIV_W'(div);
    cfg_if.cfg_mode   = 2'(mode);
    cfg_if.cfg_passes = 8'(passes);
  endtask

  task automatic do_cfg(input int div, input int mode, input int passes);
    set_cfg(div, mode, passes);
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_start(input int div, input int mode, input int passes, input int max_steps,
                          input bit with_cfg, output int k0);
    if (with_cfg) set_cfg(div, mode, passes);
    start = 1'b1;
    k0 = cyc + 1;
    push_run(k0, div, mode, passes, max_steps);
    tick();
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_sb_empty(input string name);
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_ready", int'(cfg_if.cfg_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k0, d0, o_keep;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_div    = '0;
    cfg_if.cfg_mode   = '0;
    cfg_if.cfg_passes = '0;

    vt[0] = '{0, 0, 2, 1'b0, 8'h01, 0, 14, 8'h01};
    vt[1] = '{1, 0, 3, 1'b0, 8'h01, 0, 42, 8'h80};
    vt[2] = '{0, 1, 2, 1'b0, 8'h01, 0,  8, 8'h01};
    vt[3] = '{2, 1, 1, 1'b0, 8'h01, 0, 21, 8'h80};
    vt[4] = '{0, 2, 2, 1'b1, 8'h80, 1,  8, 8'h80};
    vt[5] = '{1, 2, 1, 1'b0, 8'h80, 1, 14, 8'h01};
    vt[6] = '{0, 0, 1, 1'b1, 8'h01, 0,  7, 8'h80};

    @(negedge clock);
    chk("rst_o", int'(o), 8'h01);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cfg_if.cfg_ready), 1);
    @(posedge clock);
    #1 reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      if (!vt[v].same) do_cfg(vt[v].div, vt[v].mode, vt[v].passes);
      d0 = done_cnt;
      do_start(vt[v].div, vt[v].mode, vt[v].passes, 1000, vt[v].same, k0);
      chk($sformatf("v%0d_first_o", v), int'(o), vt[v].first_o);
      chk($sformatf("v%0d_first_dir", v), int'(dir), vt[v].first_dir);
      chk($sformatf("v%0d_busy", v), int'(busy), 1);
      chk($sformatf("v%0d_ready", v), int'(cfg_if.cfg_ready), 0);
      for (int i = 0; i < 2000; i++) begin
        if (done_cnt != d0) break;
        tick();
      end
      chk($sformatf("v%0d_done_seen", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_run_cycles", v), done_cyc - k0, vt[v].run_cyc);
      tick();
      tick();
      chk($sformatf("v%0d_one_done", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_idle_busy", v), int'(busy), 0);
      chk($sformatf("v%0d_idle_ready", v), int'(cfg_if.cfg_ready), 1);
      chk($sformatf("v%0d_hold_o", v), int'(o), vt[v].last_o);
      chk($sformatf("v%0d_sb_empty", v), sb.size(), 0);
    end

    // Rate, endless run, config and start ignored while running, then stop.
    d0 = done_cnt;
    do_cfg(3, 1, 0);
    do_start(3, 1, 0, 10, 1'b0, k0);
    tick();
    chk("run_ready", int'(cfg_if.cfg_ready), 0);
    set_cfg(0, 2, 1);
    start = 1'b1;
    wait_sb_empty("rate_sb");
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    do_stop();
    tick();
    tick();
    chk("rate_hold_o", int'(o), 8'h04);
    chk("rate_no_done", done_cnt - d0, 0);
    do_start(3, 1, 0, 3, 1'b0, k0);
    wait_sb_empty("old_cfg_sb");
    do_stop();

    // start together with stop in IDLE stays idle.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    chk("ss_busy1", int'(busy), 0);
    tick();
    chk("ss_busy2", int'(busy), 0);
    chk("ss_ready", int'(cfg_if.cfg_ready), 1);
    start = 1'b0;
    stop  = 1'b0;
    tick();

    // Asynchronous reset between edges mid-run.
    d0 = done_cnt;
    do_cfg(2, 0, 1);
    do_start(2, 0, 1, 20, 1'b0, k0);
    for (int i = 0; i < 8; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_o", int'(o), 8'h01);
    chk("arst_dir", int'(dir), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_ready", int'(cfg_if.cfg_ready), 1);
    sb.delete();
    @(posedge clock);
    #3 reset = 1'b0;
    tick();
    chk("arst_no_done", done_cnt - d0, 0);
    do_start(0, 0, 0, 4, 1'b0, k0);
    wait_sb_empty("arst_cleared_cfg_sb");
    do_stop();

    // Hold mode never steps nor completes.
    d0 = done_cnt;
    do_cfg(0, 3, 1);
    do_start(0, 3, 1, 0, 1'b0, k0);
    o_keep = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o != 8'h01) o_keep++;
    end
    chk("hold_o_changes", o_keep, 0);
    chk("hold_busy", int'(busy), 1);
    chk("hold_no_done", done_cnt - d0, 0);
    do_stop();
    chk("hold_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
